// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types and constants for the test-pattern sequencer
package pattern_pkg;

  localparam int MODE_SMPTE        = 0;
  localparam int MODE_GRID         = 1;
  localparam int NUM_MODES_DEFAULT = 2;

  localparam logic [5:0] LED_RESET = 6'b111110;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_e;

  // Active-low one-hot; modes beyond the six LEDs leave them all dark.
  function automatic logic [5:0] mode_led(input int unsigned m);
    logic [5:0] l;
    l = 6'b111111;
    for (int unsigned i = 0; i < 6; i++) begin
      if (m == i) l[i] = 1'b0;
    end
    return l;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser and debouncer producing one press event per accepted press
module btn_debounce
  import pattern_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 180000
) (
  input  logic clkd,
  input  logic reset,
  input  logic userbtn,
  output logic press_evt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             r_sync1, r_sync2;
  logic [CNT_W-1:0] r_cnt;
  deb_state_e       r_state, w_state_next;
  logic             w_cnt_clr, w_cnt_inc, w_cnt_done;

  assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clkd or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= userbtn;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // r_sync2 is the synchronised button, low while pressed.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    press_evt    = 1'b0;
    unique case (r_state)
      RELEASED: begin
        if (!r_sync2) begin
          w_state_next = PRESS_WAIT;
          w_cnt_clr    = 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (r_sync2) begin
          w_state_next = RELEASED;
        end else if (w_cnt_done) begin
          w_state_next = PRESSED;
          press_evt    = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      PRESSED: begin
        if (r_sync2) begin
          w_state_next = RELEASE_WAIT;
          w_cnt_clr    = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!r_sync2) begin
          w_state_next = PRESSED;
        end else if (w_cnt_done) begin
          w_state_next = RELEASED;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_next = RELEASED;
    endcase
  end

endmodule

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - frame-aligned test-pattern mode selection with button and auto-cycle control
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int NUM_MODES       = NUM_MODES_DEFAULT,
  parameter int MODE_W          = 3,
  parameter int DEBOUNCE_CYCLES = 180000,
  parameter int AUTO_FRAMES     = 300
) (
  input  logic              clkd,
  input  logic              reset,
  input  logic              userbtn,
  input  logic              newframe,
  input  logic              auto_en,
  output logic [MODE_W-1:0] mode,
  output logic              mode_strobe,
  output logic [5:0]        led
);

  localparam int FCNT_W = $clog2(AUTO_FRAMES + 1);

  logic              w_press_evt, w_auto_tick, w_advance;
  logic              r_pending;
  logic [FCNT_W-1:0] r_fcnt;
  logic [MODE_W-1:0] r_mode, w_mode_next;
  logic              r_strobe;
  logic [5:0]        r_led;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clkd      (clkd),
    .reset     (reset),
    .userbtn   (userbtn),
    .press_evt (w_press_evt)
  );

  assign w_auto_tick = auto_en && newframe && (r_fcnt == FCNT_W'(AUTO_FRAMES - 1));
  // A press landing on the boundary cycle is applied there, not a frame later.
  assign w_advance   = newframe && (r_pending || w_press_evt || w_auto_tick);
  assign w_mode_next = (r_mode == MODE_W'(NUM_MODES - 1)) ? '0 : r_mode + MODE_W'(1);

  always_ff @(posedge clkd or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
      r_fcnt    <= '0;
      r_mode    <= '0;
      r_strobe  <= 1'b0;
      r_led     <= LED_RESET;
    end else begin
      if (w_advance)        r_pending <= 1'b0;
      else if (w_press_evt) r_pending <= 1'b1;

      if (!auto_en || w_advance) r_fcnt <= '0;
      else if (newframe)         r_fcnt <= r_fcnt + FCNT_W'(1);

      r_strobe <= w_advance;
      if (w_advance) begin
        r_mode <= w_mode_next;
        r_led  <= mode_led(32'(w_mode_next));
      end
    end
  end

  assign mode        = r_mode;
  assign mode_strobe = r_strobe;
  assign led         = r_led;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - scoreboard bench for pattern_sequencer
module tb_pattern_sequencer;

  localparam int NM = 2;

  logic       clkd, reset, userbtn, newframe, auto_en;
  logic [2:0] mode;
  logic       mode_strobe;
  logic [5:0] led;

  int checks = 0;
  int errors = 0;
  int exp_mode = 0;
  int q_mode[$];
  int q_led[$];

  pattern_sequencer #(
    .NUM_MODES(NM), .MODE_W(3), .DEBOUNCE_CYCLES(4), .AUTO_FRAMES(3)
  ) dut (
    .clkd(clkd), .reset(reset), .userbtn(userbtn), .newframe(newframe),
    .auto_en(auto_en), .mode(mode), .mode_strobe(mode_strobe), .led(led)
  );

  initial begin
    clkd = 1'b0;
    forever #5 clkd = ~clkd;
  end

  function automatic int led_of(input int m);
    logic [5:0] l;
    l = 6'b111111;
    if (m < 6) l[m] = 1'b0;
    return int'(l);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkd);
    #1;
  endtask

  task automatic frame(input bit adv);
    newframe = 1'b1;
    if (adv) begin
      exp_mode = (exp_mode == NM - 1) ? 0 : exp_mode + 1;
      q_mode.push_back(exp_mode);
      q_led.push_back(led_of(exp_mode));
    end
    tick(1);
    newframe = 1'b0;
    chk("mode_at_boundary", int'(mode), exp_mode);
    chk("led_at_boundary", int'(led), led_of(exp_mode));
    tick(2);
  endtask

  task automatic press();
    userbtn = 1'b0;
    tick(20);
    userbtn = 1'b1;
    tick(10);
  endtask

  // Monitor: every strobe must correspond to a queued advance.
  initial begin
    forever begin
      @(negedge clkd);
      if (reset && mode_strobe) begin
        if (q_mode.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          chk("sb_mode", int'(mode), q_mode.pop_front());
          chk("sb_led", int'(led), q_led.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b0; userbtn = 1'b1; newframe = 1'b0; auto_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      userbtn  = 1'($urandom_range(0, 1));
      newframe = 1'($urandom_range(0, 1));
      auto_en  = 1'($urandom_range(0, 1));
      tick(1);
      chk("reset_mode", int'(mode), 0);
      chk("reset_led", int'(led), 6'b111110);
      chk("reset_strobe", int'(mode_strobe), 0);
    end
    userbtn = 1'b1; newframe = 1'b0; auto_en = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(3);
    for (int i = 0; i < 3; i++) frame(1'b0);

    // Clean press, then wrap
    press(); frame(1'b1);
    press(); frame(1'b1);

    // Bounce
    for (int i = 0; i < 15; i++) begin
      userbtn = ~userbtn;
      tick(2);
    end
    userbtn = 1'b1;
    tick(10);
    frame(1'b0);

    // Coalesce three presses into one advance
    press(); press(); press();
    frame(1'b1);
    frame(1'b0);

    // press_evt coinciding with newframe
    userbtn = 1'b0;
    tick(6);
    frame(1'b1);
    tick(5);
    userbtn = 1'b1;
    tick(10);
    frame(1'b0);

    // Auto-cycle every 3 frames
    auto_en = 1'b1;
    for (int i = 1; i <= 9; i++) frame(i % 3 == 0);
    frame(1'b0);
    press();
    frame(1'b1);
    frame(1'b0);
    frame(1'b0);
    frame(1'b1);
    frame(1'b0);
    auto_en = 1'b0;
    tick(3);

    // Reset during PRESS_WAIT with button held
    userbtn = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(2);
    chk("midreset_mode", int'(mode), 0);
    chk("midreset_led", int'(led), 6'b111110);
    exp_mode = 0;
    q_mode.delete();
    q_led.delete();
    reset = 1'b1;
    tick(8);
    frame(1'b1);
    frame(1'b0);
    userbtn = 1'b1;
    tick(10);
    frame(1'b0);
    press();
    frame(1'b1);

    tick(5);
    chk("scoreboard_drained", q_mode.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
